// File: rtl/uart_cpld_ctrl_pkg.sv
// Shared definitions for the CPLD UART bridge: FSM states, status bit layout
// and the MMU-visible register addresses.
package uart_cpld_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_STB,
        RD_END,
        WR_SETUP,
        WR_STB,
        WR_WAIT,
        DONE
    } state_t;

    localparam int TX_READY = 0;
    localparam int RX_READY = 1;

    localparam logic [31:0] ADDR_DATA   = 32'hBFD0_03F8;
    localparam logic [31:0] ADDR_STATUS = 32'hBFD0_03FC;

    function automatic logic [31:0] status_word(input logic rx_ready, input logic tx_ready);
        logic [31:0] w;
        w           = '0;
        w[RX_READY] = rx_ready;
        w[TX_READY] = tx_ready;
        return w;
    endfunction

endpackage

// File: rtl/uart_cpld_ctrl.sv
// Bridges single register reads/writes onto the CPLD UART sharing the BaseRAM
// data bus; strobe widths and transmit timeout are counted inline.
module uart_cpld_ctrl
    import uart_cpld_ctrl_pkg::*;
#(
    parameter int STROBE_CYC  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        sel_status,
    input  logic [7:0]  wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ram_hold,
    output logic        bus_oe,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_dataready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);

    localparam int STB_W = $clog2(STROBE_CYC + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t             state;
    logic [STB_W-1:0]   stb_cnt;
    logic [TMO_W-1:0]   wait_cnt;
    logic [7:0]         rx_byte;
    logic               tbre_seen;

    // Every output is set on the transition into the state that owns it, so
    // all of them come straight from flops and never glitch on the shared bus.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and active-low, so it lives inside the
        // clocked branch rather than in the sensitivity list.
        if (!rst) begin
            state     <= IDLE;
            stb_cnt   <= '0;
            wait_cnt  <= '0;
            rx_byte   <= '0;
            tbre_seen <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ram_hold  <= 1'b0;
            bus_oe    <= 1'b0;
            bus_dout  <= '0;
            uart_rdn  <= 1'b1;
            uart_wrn  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments only; the later assignment in a
            // branch overrides this default, giving a one-cycle done pulse.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_write) begin
                        busy <= 1'b1;
                        if (sel_status) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            state    <= WR_SETUP;
                            ram_hold <= 1'b1;
                            bus_oe   <= 1'b1;
                            bus_dout <= wdata;
                        end
                    end else if (req_read) begin
                        busy <= 1'b1;
                        if (sel_status) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                            rdata <= status_word(uart_dataready, uart_tbre & uart_tsre);
                        end else begin
                            state    <= RD_STB;
                            ram_hold <= 1'b1;
                            uart_rdn <= 1'b0;
                            stb_cnt  <= '0;
                        end
                    end
                end
                RD_STB: begin
                    if (stb_cnt == STB_LAST) begin
                        state    <= RD_END;
                        uart_rdn <= 1'b1;
                        rx_byte  <= bus_din;
                    end else begin
                        stb_cnt <= stb_cnt + STB_W'(1);
                    end
                end
                RD_END: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    err      <= 1'b0;
                    ram_hold <= 1'b0;
                    rdata    <= {24'b0, rx_byte};
                end
                WR_SETUP: begin
                    state    <= WR_STB;
                    uart_wrn <= 1'b0;
                    stb_cnt  <= '0;
                end
                WR_STB: begin
                    if (stb_cnt == STB_LAST) begin
                        state     <= WR_WAIT;
                        uart_wrn  <= 1'b1;
                        bus_oe    <= 1'b0;
                        ram_hold  <= 1'b0;
                        wait_cnt  <= '0;
                        tbre_seen <= 1'b0;
                    end else begin
                        stb_cnt <= stb_cnt + STB_W'(1);
                    end
                end
                WR_WAIT: begin
                    // Completion wins over a timeout landing on the same edge.
                    if ((tbre_seen || uart_tbre) && uart_tsre) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                    end else if (wait_cnt == TMO_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TMO_W'(1);
                        if (uart_tbre) tbre_seen <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
